// File: rtl/ysyx_24090003_csr_pkg.sv
// Shared definitions for the RV32 GPR + machine-mode CSR file: CSR map,
// CSR operation encodings, mstatus field positions and the read-modify-write helper.
package ysyx_24090003_csr_pkg;

  localparam int CSR_XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [CSR_XLEN-1:0] MCAUSE_ECALL_M = 32'd11;

  function automatic logic [CSR_XLEN-1:0] csr_apply(
    input logic [1:0]          op,
    input logic [CSR_XLEN-1:0] old_val,
    input logic [CSR_XLEN-1:0] wdata
  );
    logic [CSR_XLEN-1:0] res;
    case (op)
      OP_RW:   res = wdata;
      OP_RS:   res = old_val | wdata;
      OP_RC:   res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ysyx_24090003_csr_counter64.sv
// 64-bit machine counter; a write to either half replaces that half and
// suppresses the increment for that cycle.
module ysyx_24090003_csr_counter64
  import ysyx_24090003_csr_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inc,
  input  logic                i_wr_lo,
  input  logic                i_wr_hi,
  input  logic [CSR_XLEN-1:0] i_wdata,
  output logic [63:0]         o_value
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  // Next count: CSR write first, otherwise increment with carry into the high half
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) begin
        lo_d = i_wdata;
      end else begin
        lo_d = lo_q;
      end
      if (i_wr_hi) begin
        hi_d = i_wdata;
      end else begin
        hi_d = hi_q;
      end
    end else if (i_inc) begin
      lo_d = lo_q + 32'd1;
      if (lo_q == 32'hFFFF_FFFF) begin
        hi_d = hi_q + 32'd1;
      end else begin
        hi_d = hi_q;
      end
    end else begin
      lo_d = lo_q;
      hi_d = hi_q;
    end
  end

  // Counter state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lo_q <= 32'd0;
      hi_q <= 32'd0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign o_value = {hi_q, lo_q};

endmodule

// File: rtl/ysyx_24090003_regfile_csr.sv
// Parametrised GPR file with optional write-to-read bypass, plus the machine-mode
// CSR file (trap stacking, WARL masking, 64-bit counters, illegal-access detection).
module ysyx_24090003_regfile_csr
  import ysyx_24090003_csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NR_GPR    = 32,
  parameter int          RD_PORTS  = 2,
  parameter int          BYPASS    = 1,
  parameter logic [31:0] VENDOR_ID = 32'h7973_7978,
  parameter logic [31:0] ARCH_ID   = 32'h0165_0003
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [RD_PORTS*5-1:0]    i_rs_addr,
  output logic [RD_PORTS*XLEN-1:0] o_rs_data,
  input  logic                     i_reg_wen,
  input  logic [4:0]               i_rd_addr,
  input  logic [XLEN-1:0]          i_rd_wdata,
  input  logic                     i_csr_en,
  input  logic [11:0]              i_csr_addr,
  input  logic [1:0]               i_csr_op,
  input  logic [XLEN-1:0]          i_csr_wdata,
  input  logic                     i_csr_src_zero,
  output logic [XLEN-1:0]          o_csr_rdata,
  output logic                     o_csr_illegal,
  input  logic                     i_trap,
  input  logic [XLEN-1:0]          i_trap_cause,
  input  logic [XLEN-1:0]          i_trap_pc,
  input  logic [XLEN-1:0]          i_trap_tval,
  input  logic                     i_mret,
  input  logic                     i_retire,
  output logic [XLEN-1:0]          o_mtvec,
  output logic [XLEN-1:0]          o_mepc,
  output logic                     o_mie
);

  localparam int               IDX_W      = $clog2(NR_GPR);
  localparam logic [5:0]       NR_GPR_W   = 6'(NR_GPR);
  localparam logic [XLEN-1:0]  ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] rf_q [NR_GPR];
  logic [XLEN-1:0] rf_d [NR_GPR];
  logic            rd_ok_s;
  logic [4:0]      ra_s;

  // GPR write decode; x0 and out-of-range addresses are dropped
  always_comb begin
    rf_d    = rf_q;
    rd_ok_s = i_reg_wen && (i_rd_addr != 5'd0) && ({1'b0, i_rd_addr} < NR_GPR_W);
    if (rd_ok_s) begin
      rf_d[i_rd_addr[IDX_W-1:0]] = i_rd_wdata;
    end else begin
      rf_d = rf_q;
    end
  end

  // GPR storage
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NR_GPR; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports with optional forwarding of the write in flight
  always_comb begin
    o_rs_data = '0;
    ra_s      = 5'd0;
    for (int k = 0; k < RD_PORTS; k++) begin
      ra_s = i_rs_addr[5*k +: 5];
      if ((ra_s == 5'd0) || ({1'b0, ra_s} >= NR_GPR_W)) begin
        o_rs_data[k*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && rd_ok_s && (i_rd_addr == ra_s)) begin
        o_rs_data[k*XLEN +: XLEN] = i_rd_wdata;
      end else begin
        o_rs_data[k*XLEN +: XLEN] = rf_q[ra_s[IDX_W-1:0]];
      end
    end
  end

  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [63:0]     mcycle_s, minstret_s;
  logic [XLEN-1:0] mstatus_s;
  logic [XLEN-1:0] csr_rdata_s;
  logic [XLEN-1:0] csr_new_s;
  logic            csr_known_s;
  logic            csr_wreq_s;
  logic            csr_illegal_s;
  logic            csr_we_s;

  // CSR read mux, write-intent and legality decode
  always_comb begin
    mstatus_s = '0;
    mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_s[MSTATUS_MPIE] = mpie_q;
    mstatus_s[MSTATUS_MIE]  = mie_q;
    csr_known_s = 1'b1;
    case (i_csr_addr)
      CSR_MSTATUS:   csr_rdata_s = mstatus_s;
      CSR_MTVEC:     csr_rdata_s = mtvec_q;
      CSR_MEPC:      csr_rdata_s = mepc_q;
      CSR_MCAUSE:    csr_rdata_s = mcause_q;
      CSR_MTVAL:     csr_rdata_s = mtval_q;
      CSR_MCYCLE:    csr_rdata_s = mcycle_s[31:0];
      CSR_MINSTRET:  csr_rdata_s = minstret_s[31:0];
      CSR_MCYCLEH:   csr_rdata_s = mcycle_s[63:32];
      CSR_MINSTRETH: csr_rdata_s = minstret_s[63:32];
      CSR_MVENDORID: csr_rdata_s = VENDOR_ID;
      CSR_MARCHID:   csr_rdata_s = ARCH_ID;
      default: begin
        csr_rdata_s = '0;
        csr_known_s = 1'b0;
      end
    endcase
    case (i_csr_op)
      OP_RW:        csr_wreq_s = 1'b1;
      OP_RS, OP_RC: csr_wreq_s = !i_csr_src_zero;
      default:      csr_wreq_s = 1'b0;
    endcase
    csr_illegal_s = i_csr_en && (!csr_known_s ||
                    ((i_csr_addr[11:10] == 2'b11) && csr_wreq_s));
    csr_we_s  = i_csr_en && csr_wreq_s && !csr_illegal_s && !i_trap && !i_mret;
    csr_new_s = csr_apply(i_csr_op, csr_rdata_s, i_csr_wdata);
  end

  // CSR next state: trap beats mret beats an instruction write
  always_comb begin
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    if (i_trap) begin
      mepc_d   = i_trap_pc & ALIGN_MASK;
      mcause_d = i_trap_cause;
      mtval_d  = i_trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (i_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we_s) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin
          mie_d  = csr_new_s[MSTATUS_MIE];
          mpie_d = csr_new_s[MSTATUS_MPIE];
        end
        CSR_MTVEC:  mtvec_d  = csr_new_s & ALIGN_MASK;
        CSR_MEPC:   mepc_d   = csr_new_s & ALIGN_MASK;
        CSR_MCAUSE: mcause_d = csr_new_s;
        CSR_MTVAL:  mtval_d  = csr_new_s;
        default:    mtvec_d  = mtvec_q;
      endcase
    end else begin
      mtvec_d = mtvec_q;
    end
  end

  // CSR state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  ysyx_24090003_csr_counter64 u_mcycle (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (1'b1),
    .i_wr_lo (csr_we_s && (i_csr_addr == CSR_MCYCLE)),
    .i_wr_hi (csr_we_s && (i_csr_addr == CSR_MCYCLEH)),
    .i_wdata (csr_new_s),
    .o_value (mcycle_s)
  );

  ysyx_24090003_csr_counter64 u_minstret (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (i_retire),
    .i_wr_lo (csr_we_s && (i_csr_addr == CSR_MINSTRET)),
    .i_wr_hi (csr_we_s && (i_csr_addr == CSR_MINSTRETH)),
    .i_wdata (csr_new_s),
    .o_value (minstret_s)
  );

  assign o_csr_rdata   = csr_rdata_s;
  assign o_csr_illegal = csr_illegal_s;
  assign o_mtvec       = mtvec_q;
  assign o_mepc        = mepc_q;
  assign o_mie         = mie_q;

endmodule

// File: tb/tb_ysyx_24090003_regfile_csr.sv
// Directed + random bench for ysyx_24090003_regfile_csr (RV32E, 2 ports, bypass on),
// checked every cycle against an architectural model of the GPRs and CSRs.
module tb_ysyx_24090003_regfile_csr;

  localparam int          NR     = 16;
  localparam logic [31:0] VENDOR = 32'h7973_7978;
  localparam logic [31:0] ARCH   = 32'h0165_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic        reg_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        mret, retire;
  logic [31:0] mtvec, mepc;
  logic        mie;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24090003_regfile_csr #(
    .XLEN(32), .NR_GPR(NR), .RD_PORTS(2), .BYPASS(1),
    .VENDOR_ID(VENDOR), .ARCH_ID(ARCH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs_addr(rs_addr), .o_rs_data(rs_data),
    .i_reg_wen(reg_wen), .i_rd_addr(rd_addr), .i_rd_wdata(rd_wdata),
    .i_csr_en(csr_en), .i_csr_addr(csr_addr), .i_csr_op(csr_op),
    .i_csr_wdata(csr_wdata), .i_csr_src_zero(csr_src_zero),
    .o_csr_rdata(csr_rdata), .o_csr_illegal(csr_illegal),
    .i_trap(trap), .i_trap_cause(trap_cause), .i_trap_pc(trap_pc),
    .i_trap_tval(trap_tval), .i_mret(mret), .i_retire(retire),
    .o_mtvec(mtvec), .o_mepc(mepc), .o_mie(mie)
  );

  // Architectural model
  logic [31:0] m_gpr [32];
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
    m_mcycle = 64'd0; m_minstret = 64'd0;
  endtask

  function automatic logic m_known(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342) ||
           (a == 12'h343) || (a == 12'hB00) || (a == 12'hB02) || (a == 12'hB80) ||
           (a == 12'hB82) || (a == 12'hF11) || (a == 12'hF12);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_mcycle[31:0];
      12'hB02: return m_minstret[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB82: return m_minstret[63:32];
      12'hF11: return VENDOR;
      12'hF12: return ARCH;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_writes();
    return (csr_op == 2'b01) || ((csr_op[1] == 1'b1) && !csr_src_zero);
  endfunction

  function automatic logic m_illegal();
    return csr_en && (!m_known(csr_addr) || ((csr_addr >= 12'hC00) && m_writes()));
  endfunction

  function automatic logic [31:0] m_rs(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NR) return 32'd0;
    if (reg_wen && rd_addr == a) return rd_wdata;
    return m_gpr[a];
  endfunction

  task automatic model_update();
    logic [31:0] old_v, nv;
    bit cyc_w, ret_w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (reg_wen && rd_addr != 5'd0 && int'(rd_addr) < NR) m_gpr[rd_addr] = rd_wdata;
    old_v = m_read(csr_addr);
    case (csr_op)
      2'b01:   nv = csr_wdata;
      2'b10:   nv = old_v | csr_wdata;
      default: nv = old_v & ~csr_wdata;
    endcase
    cyc_w = 0; ret_w = 0;
    if (trap) begin
      m_mepc = {trap_pc[31:2], 2'b00};
      m_mcause = trap_cause;
      m_mtval = trap_tval;
      m_mpie = m_mie;
      m_mie = 1'b0;
    end else if (mret) begin
      m_mie = m_mpie;
      m_mpie = 1'b1;
    end else if (csr_en && m_writes() && !m_illegal()) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = {nv[31:2], 2'b00};
        12'h341: m_mepc = {nv[31:2], 2'b00};
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: begin m_mcycle[31:0] = nv; cyc_w = 1; end
        12'hB80: begin m_mcycle[63:32] = nv; cyc_w = 1; end
        12'hB02: begin m_minstret[31:0] = nv; ret_w = 1; end
        12'hB82: begin m_minstret[63:32] = nv; ret_w = 1; end
        default: ;
      endcase
    end
    if (!cyc_w) m_mcycle = m_mcycle + 64'd1;
    if (!ret_w && retire) m_minstret = m_minstret + 64'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic settle();
    #1;
    chk("rs0", rs_data[31:0], m_rs(rs_addr[4:0]));
    chk("rs1", rs_data[63:32], m_rs(rs_addr[9:5]));
    chk("csr_rdata", csr_rdata, m_read(csr_addr));
    chk("csr_illegal", 32'(csr_illegal), 32'(m_illegal()));
    chk("mtvec", mtvec, m_mtvec);
    chk("mepc", mepc, m_mepc);
    chk("mie", 32'(mie), 32'(m_mie));
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reg_wen = 0; rd_addr = 0; rd_wdata = 0; rs_addr = 0;
    csr_en = 0; csr_addr = 12'h300; csr_op = 2'b00; csr_wdata = 0; csr_src_zero = 0;
    trap = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0; retire = 0;
  endtask

  task automatic csr_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                         input logic sz);
    clr();
    csr_en = 1; csr_op = op; csr_addr = a; csr_wdata = d; csr_src_zero = sz;
  endtask

  initial begin
    logic [31:0] saved;
    clr();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rs_addr = {5'd0, 5'd5};
    settle();
    chk("rst_x5", rs_data[31:0], 32'd0);
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    chk("rst_mtvec", mtvec, 32'd0);
    advance();
    rst_n = 1;
    csr_addr = 12'hB00;
    settle(); advance();
    settle();
    chk("mcycle_after_rst", csr_rdata, 32'd1);
    advance();

    // GPR: out-of-range, bypass, x0
    clr(); reg_wen = 1; rd_addr = 5'd20; rd_wdata = 32'hDEAD;
    settle(); advance();
    clr(); rs_addr = {5'd0, 5'd20};
    settle(); chk("x20_rv32e", rs_data[31:0], 32'd0); advance();
    clr(); reg_wen = 1; rd_addr = 5'd7; rd_wdata = 32'h1234; rs_addr = {5'd7, 5'd7};
    settle(); chk("bypass_x7", rs_data[31:0], 32'h1234); advance();
    clr(); rs_addr = {5'd0, 5'd7};
    settle(); chk("stored_x7", rs_data[31:0], 32'h1234); advance();
    clr(); reg_wen = 1; rd_addr = 5'd0; rd_wdata = 32'hFFFF;
    settle(); chk("x0_write_bypass", rs_data[31:0], 32'd0); advance();
    clr(); settle(); chk("x0_read", rs_data[31:0], 32'd0); advance();

    // mtvec WARL, csrrs/csrrc on mstatus, suppressed csrrs
    csr_cmd(2'b01, 12'h305, 32'h8000_0103, 0); settle(); advance();
    clr(); settle(); chk("mtvec_warl", mtvec, 32'h8000_0100); advance();
    csr_cmd(2'b10, 12'h300, 32'h8, 0); settle(); advance();
    csr_cmd(2'b11, 12'h300, 32'h8, 0); settle(); chk("mie_set", 32'(mie), 32'd1); advance();
    clr(); settle(); chk("mie_cleared", 32'(mie), 32'd0); advance();
    csr_cmd(2'b10, 12'h305, 32'h10, 1); settle(); advance();
    clr(); settle(); chk("csrrs_srczero", mtvec, 32'h8000_0100); advance();

    // Trap with a concurrent mepc write, then mret
    csr_cmd(2'b10, 12'h300, 32'h8, 0); settle(); advance();
    csr_cmd(2'b01, 12'h341, 32'h1234_5678, 0);
    trap = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0046; trap_tval = 32'd0;
    settle(); advance();
    clr(); csr_addr = 12'h342;
    settle();
    chk("trap_mcause", csr_rdata, 32'd11);
    chk("trap_mepc", mepc, 32'h8000_0044);
    chk("trap_mie", 32'(mie), 32'd0);
    advance();
    clr(); settle(); chk("trap_mstatus", csr_rdata, 32'h0000_1880); advance();
    clr(); mret = 1; settle(); advance();
    clr(); settle(); chk("mret_mstatus", csr_rdata, 32'h0000_1888); advance();

    // mcycle carry into the high half; minstret held without retire
    csr_cmd(2'b01, 12'hB00, 32'hFFFF_FFFF, 0); settle(); advance();
    csr_cmd(2'b01, 12'hB80, 32'd0, 0); settle(); advance();
    clr(); csr_addr = 12'hB00;
    settle(); chk("mcycle_lo_held", csr_rdata, 32'hFFFF_FFFF); advance();
    settle(); chk("mcycle_lo_wrap", csr_rdata, 32'd0);
    csr_addr = 12'hB80;
    settle(); chk("mcycleh_carry", csr_rdata, 32'd1); advance();
    clr(); csr_addr = 12'hB02;
    settle(); saved = csr_rdata; advance();
    settle(); chk("minstret_hold", csr_rdata, saved); advance();

    // Read-only and unmapped CSRs
    csr_cmd(2'b01, 12'hF11, 32'h5, 0);
    settle(); chk("ro_write_illegal", 32'(csr_illegal), 32'd1);
    chk("ro_write_rdata", csr_rdata, VENDOR); advance();
    csr_cmd(2'b10, 12'hF11, 32'h0, 1);
    settle(); chk("ro_read_legal", 32'(csr_illegal), 32'd0);
    chk("ro_read_rdata", csr_rdata, VENDOR); advance();
    csr_cmd(2'b00, 12'h7C0, 32'h0, 0);
    settle(); chk("unmapped_illegal", 32'(csr_illegal), 32'd1);
    chk("unmapped_rdata", csr_rdata, 32'd0); advance();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      clr();
      rst_n    = ($urandom_range(0, 79) != 0);
      rs_addr  = 10'($urandom);
      reg_wen  = 1'($urandom);
      rd_addr  = ($urandom_range(0, 3) == 0) ? rs_addr[4:0] : 5'($urandom);
      rd_wdata = $urandom;
      csr_en   = ($urandom_range(0, 2) != 0);
      csr_op   = 2'($urandom);
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h88 : $urandom;
      csr_src_zero = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 13))
        0: csr_addr = 12'h300;  1: csr_addr = 12'h305;  2: csr_addr = 12'h341;
        3: csr_addr = 12'h342;  4: csr_addr = 12'h343;  5: csr_addr = 12'hB00;
        6: csr_addr = 12'hB02;  7: csr_addr = 12'hB80;  8: csr_addr = 12'hB82;
        9: csr_addr = 12'hF11; 10: csr_addr = 12'hF12; 11: csr_addr = 12'h7C0;
        12: csr_addr = 12'h301;
        default: csr_addr = 12'($urandom);
      endcase
      trap = ($urandom_range(0, 11) == 0);
      trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom;
      mret = !csr_en && ($urandom_range(0, 5) == 0);
      retire = 1'($urandom);
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
